// File: rtl/arbitro_mux_4_n.sv
// Purpose: 4-way round-robin arbiter with burst limit, muxing the granted requester's data onto a shared bus.
// Latency: a request sampled at an edge is granted at that same edge; y follows sel/valid combinationally.
// Backpressure: requesters wait by holding req high; a grant is kept at most MAX_BURST edges, then passed on.
module arbitro_mux_4_n #(
  parameter int N         = 3,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [N-1:0] d0,
  input  logic [N-1:0] d1,
  input  logic [N-1:0] d2,
  input  logic [N-1:0] d3,
  output logic [3:0]   gnt,
  output logic [1:0]   sel,
  output logic         valid,
  output logic [N-1:0] y
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] count;

  logic [1:0] arb_base;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       any_req;
  logic       hold;

  // Pick the winner. On a release the pointer moves past the holder in the same
  // edge, so the scan base is sel+1 while busy and the stored ptr while idle.
  always_comb begin
    arb_base = (state == BUSY) ? sel + 2'd1 : ptr;
    winner   = arb_base;
    idx      = arb_base;
    // Scan from the far end back so the closest requester to the base wins.
    for (int k = 3; k >= 0; k--) begin
      idx = arb_base + 2'(k);
      if (req[idx]) winner = idx;
    end
    any_req = |req;
    hold    = (state == BUSY) && req[sel] && (count < MAX_CNT);
  end

  // Arbitration FSM with registered grant outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      sel   <= 2'b00;
      valid <= 1'b0;
      ptr   <= 2'b00;
      count <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state <= BUSY;
            gnt   <= 4'b0001 << winner;
            sel   <= winner;
            valid <= 1'b1;
            count <= 4'd1;
          end
        end
        BUSY: begin
          if (hold) begin
            count <= count + 4'd1;
          end else begin
            ptr <= sel + 2'd1;
            if (any_req) begin
              gnt   <= 4'b0001 << winner;
              sel   <= winner;
              valid <= 1'b1;
              count <= 4'd1;
            end else begin
              state <= IDLE;
              gnt   <= 4'b0000;
              valid <= 1'b0;
              count <= 4'd0;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 4'b0000;
          valid <= 1'b0;
          count <= 4'd0;
        end
      endcase
    end
  end

  // Shared bus: granted requester's data, forced to zero when nothing is granted.
  always_comb begin
    y = '0;
    if (valid) begin
      case (sel)
        2'd0:    y = d0;
        2'd1:    y = d1;
        2'd2:    y = d2;
        default: y = d3;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_mux_4_n.sv
// Purpose: self-checking bench for arbitro_mux_4_n using a per-edge scoreboard of expected outputs.
// Latency: expectations are pushed as stimulus is driven and popped 1 time unit after the edge.
// Backpressure: none; requests are driven directly by each scenario task.
module tb_arbitro_mux_4_n;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic [2:0] y;
  } obs_t;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [2:0] d0, d1, d2, d3;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic [2:0] y;

  int n_checks;
  int n_fail;
  obs_t sb[$];

  arbitro_mux_4_n #(.N(3), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .gnt(gnt), .sel(sel), .valid(valid), .y(y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required normal end");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] dval(input logic [1:0] i);
    case (i)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b101;
      default: return 3'b111;
    endcase
  endfunction

  function automatic obs_t mk(input logic v, input logic [1:0] s);
    obs_t o;
    o.valid = v;
    o.sel   = s;
    o.gnt   = v ? (4'b0001 << s) : 4'b0000;
    o.y     = v ? dval(s) : 3'b000;
    return o;
  endfunction

  // Drive one edge worth of inputs, then move 1 unit past the edge for sampling.
  task automatic cyc(input logic r, input logic [3:0] q);
    rst = r;
    req = q;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    obs_t got, exp;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(1'b0, 2'd0));
      cyc(1'b1, 4'b1111);
      got = {gnt, sel, valid, y};
      exp = sb.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %b required %b", i, got, exp);
      end
    end
  endtask

  task automatic test_first_grant;
    obs_t got, exp;
    cyc(1'b1, 4'b0000);
    sb.push_back(mk(1'b1, 2'd0));
    cyc(1'b0, 4'b0101);
    got = {gnt, sel, valid, y};
    exp = sb.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL first_grant: got %b required %b", got, exp);
    end
  endtask

  // Six edges of a lone requester 0, then 0011: the burst restarted after 4,
  // so it runs two more edges (counts 3,4) before handing over to requester 1.
  task automatic test_burst;
    obs_t got, exp;
    logic [3:0] q;
    cyc(1'b1, 4'b0000);
    for (int i = 0; i < 9; i++) begin
      q = (i < 6) ? 4'b0001 : 4'b0011;
      sb.push_back(mk(1'b1, (i == 8) ? 2'd1 : 2'd0));
      cyc(1'b0, q);
      got = {gnt, sel, valid, y};
      exp = sb.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL burst[%0d]: got %b required %b", i, got, exp);
      end
    end
  endtask

  task automatic test_rotate;
    obs_t got, exp;
    cyc(1'b1, 4'b0000);
    for (int i = 0; i < 17; i++) begin
      sb.push_back(mk(1'b1, 2'((i / 4) % 4)));
      cyc(1'b0, 4'b1111);
      got = {gnt, sel, valid, y};
      exp = sb.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rotate[%0d]: got %b required %b", i, got, exp);
      end
    end
  endtask

  task automatic test_drop;
    obs_t got, exp;
    cyc(1'b1, 4'b0000);
    sb.push_back(mk(1'b1, 2'd0));
    sb.push_back(mk(1'b1, 2'd0));
    sb.push_back(mk(1'b1, 2'd2));
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, (i < 2) ? 4'b0101 : 4'b0100);
      got = {gnt, sel, valid, y};
      exp = sb.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL drop[%0d]: got %b required %b", i, got, exp);
      end
    end
  endtask

  task automatic test_rst_mid;
    obs_t got, exp;
    cyc(1'b1, 4'b0000);
    sb.push_back(mk(1'b1, 2'd2));
    cyc(1'b0, 4'b0100);
    sb.push_back(mk(1'b0, 2'd0));
    cyc(1'b1, 4'b0100);
    sb.push_back(mk(1'b1, 2'd0));
    cyc(1'b0, 4'b1001);
    // Three edges were driven; the queue holds their expectations in order,
    // so only the last observation is still visible. Re-run to compare each.
    sb.delete();
    cyc(1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin sb.push_back(mk(1'b1, 2'd2)); cyc(1'b0, 4'b0100); end
        1: begin sb.push_back(mk(1'b0, 2'd0)); cyc(1'b1, 4'b0100); end
        default: begin sb.push_back(mk(1'b1, 2'd0)); cyc(1'b0, 4'b1001); end
      endcase
      got = {gnt, sel, valid, y};
      exp = sb.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rst_mid[%0d]: got %b required %b", i, got, exp);
      end
    end
  endtask

  // Release from requester 3 to idle: sel holds 3, and ptr wraps to 0.
  task automatic test_idle_release;
    obs_t got, exp;
    obs_t e;
    cyc(1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin sb.push_back(mk(1'b1, 2'd3)); cyc(1'b0, 4'b1000); end
        1: begin e = mk(1'b0, 2'd3); sb.push_back(e); cyc(1'b0, 4'b0000); end
        default: begin sb.push_back(mk(1'b1, 2'd0)); cyc(1'b0, 4'b1001); end
      endcase
      got = {gnt, sel, valid, y};
      exp = sb.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL idle_release[%0d]: got %b required %b", i, got, exp);
      end
    end
  endtask

  // A request pulse that rises and falls between two edges must not be granted.
  task automatic test_glitch;
    obs_t got, exp;
    cyc(1'b1, 4'b0000);
    sb.push_back(mk(1'b0, 2'd0));
    rst = 1'b0;
    req = 4'b0000;
    #2 req = 4'b1111;
    #3 req = 4'b0000;
    @(posedge clk);
    #1;
    got = {gnt, sel, valid, y};
    exp = sb.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL glitch: got %b required %b", got, exp);
    end
  endtask

  // Random traffic checked against a behavioural reference model.
  task automatic test_random;
    obs_t got, exp;
    logic       m_valid;
    logic [1:0] m_sel, m_ptr, base, cand;
    int         m_cnt;
    logic       r;
    logic [3:0] q;
    bit         found;
    m_valid = 1'b0; m_sel = 2'd0; m_ptr = 2'd0; m_cnt = 0;
    cyc(1'b1, 4'b0000);
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 39) == 0);
      q = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) q = 4'b0000;
      if (r) begin
        m_valid = 1'b0; m_sel = 2'd0; m_ptr = 2'd0; m_cnt = 0;
      end else if (m_valid && q[m_sel] && m_cnt < 4) begin
        m_cnt++;
      end else begin
        if (m_valid) m_ptr = m_sel + 2'd1;
        base  = m_ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          cand = base + 2'(k);
          if (!found && q[cand]) begin
            found = 1'b1;
            m_sel = cand;
          end
        end
        m_valid = found;
        m_cnt   = found ? 1 : 0;
      end
      sb.push_back(mk(m_valid, m_sel));
      cyc(r, q);
      got = {gnt, sel, valid, y};
      exp = sb.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random[%0d] req=%b rst=%b: got %b required %b", i, q, r, got, exp);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    req = 4'b0000;
    d0 = 3'b001; d1 = 3'b010; d2 = 3'b101; d3 = 3'b111;
    #1;
    test_reset;
    test_first_grant;
    test_burst;
    test_rotate;
    test_drop;
    test_rst_mid;
    test_idle_release;
    test_glitch;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arbitro_mux_4_n.md
ARBITRO_MUX_4_N -- requirements
Module: arbitro_mux_4_N

Interface
REQ-001 Parameter N, default 3: width of each data input and of the output.
REQ-002 Parameter MAX_BURST, default 4: maximum consecutive cycles one grant is held, legal range 1..15.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Port req  input  4: request vector; bit i is requester i.
REQ-006 Ports d0, d1, d2, d3  input  N each: data from requesters 0..3.
REQ-007 Port gnt  output  4: registered grant, one-hot or all-zero.
REQ-008 Port sel  output  2: registered index of the granted requester.
REQ-009 Port valid  output  1: registered; 1 while any grant is active.
REQ-010 Port y  output  N: shared-bus data output.

Function
REQ-011 The block SHALL implement a two-state FSM, IDLE (no grant) and BUSY (one grant active).
REQ-012 The block SHALL keep a 2-bit priority pointer ptr; arbitration picks the first set req bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-013 IDLE: if req != 0 at an edge, that edge SHALL load gnt = one-hot(winner), sel = winner, valid = 1, burst count = 1, and move to BUSY; if req == 0, stay in IDLE with outputs unchanged.
REQ-014 Grant latency SHALL be exactly one edge: req sampled at edge k produces gnt at edge k.
REQ-015 BUSY: if req[sel] = 1 and count < MAX_BURST, the grant SHALL be held and count incremented.
REQ-016 BUSY release: if req[sel] = 0 or count == MAX_BURST, the block SHALL set ptr = sel+1 (mod 4) and re-arbitrate in the same edge using the new ptr.
REQ-017 On re-arbitration with req != 0, the new grant SHALL appear on that edge with count = 1 and no idle cycle.
REQ-018 On re-arbitration with req == 0, the block SHALL go to IDLE with gnt = 0000 and valid = 0; sel holds its last value.
REQ-019 If the releasing holder is the only requester, it SHALL be re-granted immediately with count = 1, and valid stays 1.
REQ-020 gnt SHALL always equal one-hot(sel) when valid = 1, and 0000 when valid = 0.
REQ-021 y SHALL be combinational: d[sel] when valid = 1, all zeros when valid = 0.
REQ-022 Requests asserted and dropped between edges SHALL be ignored; only values at the edge count.
REQ-023 The count register SHALL be 4 bits wide and never exceed MAX_BURST.

Reset
REQ-024 When rst = 1 at an edge, the block SHALL force state = IDLE, gnt = 0000, sel = 00, valid = 0, ptr = 00, count = 0, regardless of req.
REQ-025 rst SHALL take priority over all arbitration; a grant active when reset arrives SHALL be dropped at that edge.
REQ-026 After rst is released, the first arbitration SHALL give requester 0 highest priority.

Verification (N=3, MAX_BURST=4, d0=001, d1=010, d2=101, d3=111)
REQ-027 Reset, then req=0101 at one edge -> gnt=0001, sel=00, valid=1, y=001.
REQ-028 req=0001 held for 6 edges -> gnt=0001 at every edge, valid never drops, count sequence 1,2,3,4,1,2.
REQ-029 req=1111 held -> gnt sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001; y follows 001, 010, 101, 111.
REQ-030 Holder 0 granted, req=0101, then req[0] drops after 2 cycles -> next edge gnt=0100, y=101, no valid gap.
REQ-031 rst asserted during a grant of requester 2 -> that edge gnt=0000, valid=0, y=000; then release rst with req=1001 -> gnt=0001.
REQ-032 Grant on requester 3 with req falling to 0000 -> gnt=0000, valid=0, y=000; then req=1001 -> gnt=0001, because ptr = 0 after release from requester 3.
